// File: rtl/apply_force_array.sv
// Multi-channel force-to-duty converter sharing one 64-bit restoring divider.
// Define APPLY_FORCE_SLEW_EN to rate-limit each duty update by SLEW_STEP.
module apply_force_array #(
  parameter int CHANNELS           = 2,
  parameter int WIDTH              = 32,
  parameter int FORCE_LIMIT        = 27,
  parameter int FRICTION_SLOPE     = 362361,
  parameter int FRICTION_INTERCEPT = 8,
  parameter int STATIC_FRICTION    = 4,
  parameter int FULL_FORCE         = 29,
  parameter int CLK_HZ             = 50000000,
  parameter int PPR                = 400,
  parameter int GAIN_NUM           = 60,
  parameter int GAIN_DEN           = 98,
  parameter int DUTY_MAX           = 524287,
  parameter int SLEW_STEP          = 65536
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CHANNELS*WIDTH-1:0] f_newtons,
  input  logic [CHANNELS*WIDTH-1:0] period,
  output logic                      busy,
  output logic                      done,
  output logic [CHANNELS*WIDTH-1:0] duty_cycle,
  output logic [CHANNELS-1:0]       sat
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] PERIOD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [63:0] FULL_NUM = 64'(CLK_HZ) * 64'd60;
  localparam logic signed [63:0] C_FL = 64'(FORCE_LIMIT);
  localparam logic signed [63:0] C_FI = 64'(FRICTION_INTERCEPT);
  localparam logic signed [63:0] C_SF = 64'(STATIC_FRICTION);
  localparam logic signed [63:0] C_FF = 64'(FULL_FORCE);
  localparam logic signed [63:0] C_DM = 64'(DUTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_DIV_FRIC, S_FORCE,
    S_DIV_FULL, S_DIV_DUTY, S_STORE, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [6:0]  r_cnt;
  logic        w_div, w_last;
  logic [CW-1:0] r_ch;
  logic        w_last_ch;

  logic [CHANNELS*WIDTH-1:0] r_fsnap, r_psnap, r_duty;
  logic [CHANNELS-1:0]       r_sat;

  logic signed [WIDTH-1:0] w_fsel, w_psel;
  logic w_pstop;

  logic signed [63:0] r_f, r_fuse, r_fullf;
  logic signed [63:0] w_kin, w_fric, w_freq, w_fuse;
  logic signed [63:0] w_fullf, w_fmag, w_mag, w_dfull, w_duty;
  logic r_stop, r_neg, r_fsat, w_fsat, w_dsat;

  logic [63:0] r_pabs, r_rem, r_quo, r_dvs, w_dvd, w_dvs;
  logic [64:0] w_shift, w_diff;

  assign w_div = (r_state == S_DIV_FRIC) || (r_state == S_DIV_FULL) ||
                 (r_state == S_DIV_DUTY);
  assign w_last    = (r_cnt == 7'd64);
  assign w_last_ch = (r_ch == CW'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start) w_next = S_PREP;
      S_PREP:     w_next = S_DIV_FRIC;
      S_DIV_FRIC: if (w_last) w_next = S_FORCE;
      S_FORCE:    w_next = S_DIV_FULL;
      S_DIV_FULL: if (w_last) w_next = S_DIV_DUTY;
      S_DIV_DUTY: if (w_last) w_next = S_STORE;
      S_STORE:    w_next = w_last_ch ? S_DONE : S_PREP;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ch  <= '0;
    end else begin
      r_cnt <= (w_div && !w_last) ? r_cnt + 7'd1 : 7'd0;
      if (r_state == S_IDLE && start) r_ch <= '0;
      else if (r_state == S_STORE && !w_last_ch) r_ch <= r_ch + CW'(1);
    end
  end

  always_comb begin
    w_fsel  = r_fsnap[int'(r_ch)*WIDTH +: WIDTH];
    w_psel  = r_psnap[int'(r_ch)*WIDTH +: WIDTH];
    w_pstop = (w_psel == '0) || (w_psel == PERIOD_MAX);
  end

  // Friction and force clamp, evaluated on the DIV_FRIC quotient
  always_comb begin
    w_kin = $signed(r_quo) - C_FI;
    if (r_stop) begin
      if (r_f > 64'sd0)      w_fric = -C_SF;
      else if (r_f < 64'sd0) w_fric = C_SF;
      else                   w_fric = 64'sd0;
    end else begin
      w_fric = r_neg ? -w_kin : w_kin;
    end
    w_freq = (r_f == 64'sd0) ? 64'sd0 : r_f - w_fric;
    w_fuse = w_freq;
    w_fsat = 1'b0;
    if (w_freq > C_FL) begin
      w_fuse = C_FL;
      w_fsat = 1'b1;
    end else if (w_freq < -C_FL) begin
      w_fuse = -C_FL;
      w_fsat = 1'b1;
    end
  end

  assign w_fullf = r_stop ? C_FF : C_FF - $signed(r_quo);
  assign w_fmag  = r_fuse[63] ? -r_fuse : r_fuse;

  // Unused quotients divide by 1 so latency never depends on data
  always_comb begin
    w_dvd = '0;
    w_dvs = 64'd1;
    unique case (r_state)
      S_DIV_FRIC: begin
        w_dvd = 64'(FRICTION_SLOPE);
        if (!r_stop) w_dvs = r_pabs;
      end
      S_DIV_FULL: begin
        w_dvd = FULL_NUM;
        if (!r_stop) w_dvs = r_pabs * 64'(PPR) * 64'd51;
      end
      S_DIV_DUTY: begin
        w_dvd = w_fmag * 64'(GAIN_NUM) * 64'(DUTY_MAX);
        if (r_fuse != 64'sd0 && w_fullf > 64'sd0)
          w_dvs = 64'(GAIN_DEN) * w_fullf;
      end
      default: ;
    endcase
  end

  assign w_shift = {r_rem, r_quo[63]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (w_div) begin
      if (r_cnt == 7'd0) begin
        r_rem <= '0;
        r_quo <= w_dvd;
        r_dvs <= w_dvs;
      end else if (!w_diff[64]) begin
        r_rem <= w_diff[63:0];
        r_quo <= {r_quo[62:0], 1'b1};
      end else begin
        r_rem <= w_shift[63:0];
        r_quo <= {r_quo[62:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_fsnap <= f_newtons;
      r_psnap <= period;
    end
    if (r_state == S_PREP) begin
      r_f    <= 64'(w_fsel);
      r_stop <= w_pstop;
      r_neg  <= w_psel[WIDTH-1];
      r_pabs <= w_psel[WIDTH-1] ? -(64'(w_psel)) : 64'(w_psel);
    end
    if (r_state == S_FORCE) begin
      r_fuse <= w_fuse;
      r_fsat <= w_fsat;
    end
    if (r_state == S_DIV_DUTY && r_cnt == 7'd0) r_fullf <= w_fullf;
  end

  always_comb begin
    w_mag  = 64'sd0;
    w_dsat = 1'b0;
    if (r_fuse == 64'sd0) begin
      w_mag = 64'sd0;
    end else if (r_fullf <= 64'sd0) begin
      w_mag  = C_DM;
      w_dsat = 1'b1;
    end else if (r_quo > 64'(DUTY_MAX)) begin
      w_mag  = C_DM;
      w_dsat = 1'b1;
    end else begin
      w_mag = $signed(r_quo);
    end
    w_dfull = r_fuse[63] ? -w_mag : w_mag;
  end

`ifdef APPLY_FORCE_SLEW_EN
  logic signed [WIDTH-1:0] w_dsel;
  logic signed [63:0]      w_prev;
  localparam logic signed [63:0] C_SS = 64'(SLEW_STEP);

  always_comb begin
    w_dsel = r_duty[int'(r_ch)*WIDTH +: WIDTH];
    w_prev = 64'(w_dsel);
    w_duty = w_dfull;
    if (w_dfull > w_prev + C_SS)      w_duty = w_prev + C_SS;
    else if (w_dfull < w_prev - C_SS) w_duty = w_prev - C_SS;
  end
`else
  assign w_duty = w_dfull;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty <= '0;
      r_sat  <= '0;
    end else if (r_state == S_STORE) begin
      r_duty[int'(r_ch)*WIDTH +: WIDTH] <= w_duty[WIDTH-1:0];
      r_sat[r_ch] <= r_fsat | w_dsat;
    end
  end

  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign duty_cycle = r_duty;
  assign sat        = r_sat;

endmodule

// File: tb/tb_apply_force_array.sv
// Directed self-checking bench for apply_force_array (CHANNELS=2).
// A second instance with FORCE_LIMIT=2000 exercises the duty clamp.
module tb_apply_force_array;

  localparam logic signed [31:0] PMAX = 32'sh7FFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] f_in = '0;
  logic [63:0] p_in = '0;
  logic        busy, done, busy2, done2;
  logic [63:0] duty, duty2;
  logic [1:0]  sat, sat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apply_force_array dut (
    .clk(clk), .rst(rst), .start(start),
    .f_newtons(f_in), .period(p_in),
    .busy(busy), .done(done),
    .duty_cycle(duty), .sat(sat)
  );

  apply_force_array #(.FORCE_LIMIT(2000)) dut_big (
    .clk(clk), .rst(rst), .start(start),
    .f_newtons(f_in), .period(p_in),
    .busy(busy2), .done(done2),
    .duty_cycle(duty2), .sat(sat2)
  );

  function automatic logic signed [31:0] dch(input logic [63:0] v,
                                             input int k);
    dch = v[k*32 +: 32];
  endfunction

  task automatic set_in(input logic signed [31:0] f0,
                        input logic signed [31:0] p0,
                        input logic signed [31:0] f1,
                        input logic signed [31:0] p1);
    f_in = {f1, f0};
    p_in = {p1, p0};
  endtask

  // Starts a sweep and waits (bounded) for done; lat counts from start.
  task automatic run_sweep(output int lat, output logic b_first,
                           output logic b_done, output logic d_after);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    b_first = busy;
    while (!done && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    b_done = busy;
    @(posedge clk); #1;
    d_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    if (duty !== 64'd0) begin
      errors++; $display("FAIL reset_duty got %0h want 0", duty);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0",
                         busy, done);
    end
    checks++;
    if (sat !== 2'b00) begin
      errors++; $display("FAIL reset_sat got %b want 00", sat);
    end
    checks++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stopped;
    int lat; logic bf, bd, da;
    set_in(10, PMAX, 0, 0);
    run_sweep(lat, bf, bd, da);
    if (lat !== 397) begin
      errors++; $display("FAIL stop_latency got %0d want 397", lat);
    end
    checks++;
    if (bf !== 1'b1) begin
      errors++; $display("FAIL stop_busy_rise got %b want 1", bf);
    end
    checks++;
    if (bd !== 1'b0 || da !== 1'b0) begin
      errors++; $display("FAIL stop_done_shape got busy=%b next_done=%b want 0 0",
                         bd, da);
    end
    checks++;
    if (dch(duty, 0) !== 32'sd154961) begin
      errors++; $display("FAIL stop_duty0 got %0d want 154961", dch(duty, 0));
    end
    checks++;
    if (dch(duty, 1) !== 32'sd0 || sat !== 2'b00) begin
      errors++; $display("FAIL stop_ch1 got duty=%0d sat=%b want 0 00",
                         dch(duty, 1), sat);
    end
    checks++;
  endtask

  task automatic test_force_clamp;
    int lat; logic bf, bd, da;
    set_in(100, 0, 0, 0);
    run_sweep(lat, bf, bd, da);
    if (dch(duty, 0) !== 32'sd298854) begin
      errors++; $display("FAIL fclamp_duty0 got %0d want 298854", dch(duty, 0));
    end
    checks++;
    if (dch(duty, 1) !== 32'sd0) begin
      errors++; $display("FAIL fclamp_duty1 got %0d want 0", dch(duty, 1));
    end
    checks++;
    if (sat !== 2'b01) begin
      errors++; $display("FAIL fclamp_sat got %b want 01", sat);
    end
    checks++;
  endtask

  task automatic test_kinetic;
    int lat; logic bf, bd, da;
    set_in(20, 20000, -20, -20000);
    run_sweep(lat, bf, bd, da);
    if (dch(duty, 0) !== 32'sd145905) begin
      errors++; $display("FAIL kin_duty0 got %0d want 145905", dch(duty, 0));
    end
    checks++;
    if (dch(duty, 1) !== -32'sd145905) begin
      errors++; $display("FAIL kin_duty1 got %0d want -145905", dch(duty, 1));
    end
    checks++;
    if (sat !== 2'b00) begin
      errors++; $display("FAIL kin_sat got %b want 00", sat);
    end
    checks++;
  endtask

  task automatic test_fullf_neg;
    int lat; logic bf, bd, da;
    set_in(360, 1000, -5, 0);
    run_sweep(lat, bf, bd, da);
    if (dch(duty, 0) !== 32'sd524287) begin
      errors++; $display("FAIL fneg_duty0 got %0d want 524287", dch(duty, 0));
    end
    checks++;
    if (dch(duty, 1) !== -32'sd99618) begin
      errors++; $display("FAIL fneg_duty1 got %0d want -99618", dch(duty, 1));
    end
    checks++;
    if (sat !== 2'b01) begin
      errors++; $display("FAIL fneg_sat got %b want 01", sat);
    end
    checks++;
  endtask

  task automatic test_friction_cancel;
    int lat; logic bf, bd, da;
    set_in(10, 20000, 30, -20000);
    run_sweep(lat, bf, bd, da);
    if (dch(duty, 0) !== 32'sd0) begin
      errors++; $display("FAIL cancel_duty0 got %0d want 0", dch(duty, 0));
    end
    checks++;
    if (dch(duty, 1) !== 32'sd393944) begin
      errors++; $display("FAIL cancel_duty1 got %0d want 393944", dch(duty, 1));
    end
    checks++;
    if (sat !== 2'b10) begin
      errors++; $display("FAIL cancel_sat got %b want 10", sat);
    end
    checks++;
  endtask

  task automatic test_duty_clamp;
    int lat; logic bf, bd, da;
    logic signed [31:0] e0, e1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1000, 0, -1000, PMAX);
    for (int s = 0; s < 2; s++) begin
      run_sweep(lat, bf, bd, da);
`ifdef APPLY_FORCE_SLEW_EN
      e0 = (s == 0) ? 32'sd65536 : 32'sd131072;
`else
      e0 = 32'sd524287;
      if (dch(duty, 0) !== 32'sd298854 || dch(duty, 1) !== -32'sd298854) begin
        errors++; $display("FAIL dclamp_small got %0d %0d want 298854 -298854",
                           dch(duty, 0), dch(duty, 1));
      end
      checks++;
`endif
      e1 = -e0;
      if (dch(duty2, 0) !== e0) begin
        errors++; $display("FAIL dclamp_duty0 sweep %0d got %0d want %0d",
                           s, dch(duty2, 0), e0);
      end
      checks++;
      if (dch(duty2, 1) !== e1) begin
        errors++; $display("FAIL dclamp_duty1 sweep %0d got %0d want %0d",
                           s, dch(duty2, 1), e1);
      end
      checks++;
      if (sat2 !== 2'b11) begin
        errors++; $display("FAIL dclamp_sat sweep %0d got %b want 11", s, sat2);
      end
      checks++;
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, ndone, first;
    set_in(20, 20000, -20, -20000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; ndone = 0; first = 0;
    while (cyc < 800) begin
      if (cyc == 100) begin
        start = 1'b1;
        set_in(100, 0, 100, 0);
      end
      if (cyc == 101) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        ndone++;
        if (first == 0) first = cyc;
      end
    end
    if (ndone !== 1 || first !== 397) begin
      errors++; $display("FAIL ignore_done got count=%0d at=%0d want 1 397",
                         ndone, first);
    end
    checks++;
    if (dch(duty, 0) !== 32'sd145905 || dch(duty, 1) !== -32'sd145905) begin
      errors++; $display("FAIL ignore_snapshot got %0d %0d want 145905 -145905",
                         dch(duty, 0), dch(duty, 1));
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int cyc, ndone, lat; logic bf, bd, da;
    set_in(10, PMAX, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 250) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (dch(duty, 0) !== 32'sd154961 || dch(duty, 1) !== -32'sd145905) begin
      errors++; $display("FAIL mid_partial got %0d %0d want 154961 -145905",
                         dch(duty, 0), dch(duty, 1));
    end
    checks++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (duty !== 64'd0 || sat !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got duty=%0h sat=%b busy=%b done=%b want 0",
                         duty, sat, busy, done);
    end
    checks++;
    ndone = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    if (ndone !== 0) begin
      errors++; $display("FAIL mid_no_done got %0d want 0", ndone);
    end
    checks++;
    set_in(10, PMAX, 0, 0);
    run_sweep(lat, bf, bd, da);
    if (lat !== 397 || dch(duty, 0) !== 32'sd154961 || dch(duty, 1) !== 32'sd0) begin
      errors++; $display("FAIL mid_restart got lat=%0d %0d %0d want 397 154961 0",
                         lat, dch(duty, 0), dch(duty, 1));
    end
    checks++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stopped();
    test_force_clamp();
    test_kinetic();
    test_fullf_neg();
    test_friction_cancel();
    test_duty_clamp();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apply_force_array.md
# apply_force_array

Multi-channel, sequential successor to the single-channel force-to-duty converter. It takes a requested force and the measured encoder period for each of `CHANNELS` motors. It applies static and kinetic friction compensation, a force limit and a back-EMF full-force model, and produces a signed PWM duty command per channel for the downstream `motor_driver` instances. One shared 64-bit iterative divider serves all channels, which keeps area small.

## Interface
- `CHANNELS`, 2: number of motor channels.
- `WIDTH`, 32: width of force, period and duty words (signed, two's complement).
- `FORCE_LIMIT`, 27: clamp on the compensated force, in newtons.
- `FRICTION_SLOPE`, 362361: kinetic friction slope numerator.
- `FRICTION_INTERCEPT`, 8: kinetic friction intercept.
- `STATIC_FRICTION`, 4: friction applied when the motor is stopped.
- `FULL_FORCE`, 29: force available at full duty with zero speed.
- `CLK_HZ`, 50000000: encoder timebase frequency.
- `PPR`, 400: encoder pulses per revolution.
- `GAIN_NUM`, 60 and `GAIN_DEN`, 98: force-to-duty gain ratio.
- `DUTY_MAX`, 524287: duty magnitude limit.
- `SLEW_STEP`, 65536: maximum duty change per update (used only with the slew feature).
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request to recompute all channels.
- `f_newtons` input CHANNELS*WIDTH: requested force per channel; channel k occupies bits [k*WIDTH +: WIDTH].
- `period` input CHANNELS*WIDTH: signed encoder period per channel. 0 or 2^(WIDTH-1)-1 (`PERIOD_MAX`) means stopped.
- `busy` output 1: a computation sweep is in progress.
- `done` output 1: one-cycle pulse when all duty registers have been updated.
- `duty_cycle` output CHANNELS*WIDTH: registered signed duty per channel.
- `sat` output CHANNELS: per-channel flag, set when the force clamp or duty clamp was applied in the last update.

## Operation
- In IDLE, a cycle with `start`=1 snapshots all `f_newtons`/`period` into internal registers, sets `busy`, and selects channel 0. The block ignores input changes while busy, and ignores `start` while busy.
- Per channel, the fixed state sequence is: PREP(1) → DIV_FRIC(65) → FORCE(1) → DIV_FULL(65) → DIV_DUTY(65) → STORE(1) = 198 cycles. STORE either advances to the next channel or goes to DONE(1) → IDLE.
- cdir = 0 if period ∈ {0, PERIOD_MAX}, otherwise sign(period). All period arithmetic uses |period|.
- Friction:
  - cdir=0: −sign(f)·STATIC_FRICTION.
  - otherwise: cdir·(FRICTION_SLOPE/|period| − FRICTION_INTERCEPT).
- f_req = 0 if f=0, otherwise f − friction. f_use = clamp(f_req, ±FORCE_LIMIT); `sat` is set if this clamp is active.
- fullf:
  - cdir=0: FULL_FORCE.
  - otherwise: FULL_FORCE − (CLK_HZ·60)/(|period|·PPR·51).
- duty = sign(f_use)·(GAIN_NUM·|f_use|·DUTY_MAX)/(GAIN_DEN·fullf), then clamped to ±DUTY_MAX; `sat` is set if this clamp is active.
  - If f_use=0, duty=0.
  - If fullf≤0 and f_use≠0, duty=sign(f_use)·DUTY_MAX and `sat`=1.
- Divider: unsigned restoring, 64-bit dividend and 64-bit divisor, 1 load cycle plus 64 iterate cycles. All quotients truncate toward zero and the sign is applied afterwards.
  - When a division result is unused (stopped motor, f_use=0, fullf≤0), the divisor is forced to 1 and the result is discarded. The divider therefore never divides by zero, and latency is fixed.
- All intermediate products are 64-bit; CLK_HZ·60 exceeds 32 bits.

## Timing
- Reset values: `busy`=0, `done`=0, every `duty_cycle` channel = 0, `sat`=0, state=IDLE.
- Reset asserted mid-sweep aborts the sweep immediately and clears all outputs, including duty registers already updated.
- `busy` rises the cycle after `start` is accepted. The channel k duty register and `sat[k]` update at the end of its STORE cycle. Other channels hold their previous values until their own STORE.
- `done` pulses for exactly one cycle, CHANNELS·198+1 cycles after `start` was accepted. `busy` falls in the same cycle `done` is high.
- A new `start` is accepted on the cycle after `done`.
- Latency is independent of data.

## Configuration
- `APPLY_FORCE_SLEW_EN` defined: in STORE, the new duty is limited to previous ± SLEW_STEP per channel. Hitting this limit does not set `sat`. Reset still forces duty to 0.
- `APPLY_FORCE_SLEW_EN` undefined: STORE writes the computed duty directly. The SLEW_STEP parameter is ignored.

## Test plan
- Reset → all duty 0, `busy` 0, `done` 0, `sat` 0. `start` with ch0 f=10, period=PERIOD_MAX → ch0 duty=154961, sat=0; `done` 397 cycles after `start` (CHANNELS=2).
- ch0 f=100, period=0 → f_use clamped to 27, duty=298854, sat[0]=1. ch1 f=0 → duty 0, sat[1]=0.
- ch0 f=20, period=20000 → friction 10, fullf 22, duty=145905. ch1 f=−20, period=−20000 → duty=−145905.
- Stopped motor, f=1000 with FORCE_LIMIT overridden to 2000 → duty clamped to 524287, sat=1. With `APPLY_FORCE_SLEW_EN` from duty 0: duty=65536, then 131072 on the next sweep.
- `start` pulsed again at cycle 100 of a sweep → ignored; single `done` at cycle 397. Snapshot inputs changed mid-sweep → results reflect the originally sampled values.
- `rst` at cycle 250 after ch0 has stored → all duty 0, `busy` 0, no `done` pulse; a fresh `start` completes normally.
